// File: rtl/vape_exec_flag_multi.sv
// Multi-region EXEC-validity monitor: one EXEC/ABORT flag per region, lost on any CPU/DMA
// write into the region and regained only when the PC reaches the reset handler.
module vape_exec_flag_multi #(
   parameter int unsigned          N_REGIONS     = 2,
   parameter int unsigned          AW            = 16,
   parameter int unsigned          CNT_W         = 4,
   parameter logic [AW-1:0]        RESET_HANDLER = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AW-1:0]              pc,
   input  logic [AW-1:0]              data_addr,
   input  logic                       data_en,
   input  logic [AW-1:0]              dma_addr,
   input  logic                       dma_en,
   input  logic [N_REGIONS*AW-1:0]    exec_min,
   input  logic [N_REGIONS*AW-1:0]    exec_max,
   input  logic [N_REGIONS-1:0]       region_en,
   output logic [N_REGIONS-1:0]       exec_fail,
   output logic                       any_fail,
   output logic [N_REGIONS-1:0]       cause_cpu,
   output logic [N_REGIONS-1:0]       cause_dma,
   output logic [N_REGIONS*CNT_W-1:0] abort_cnt
);

   typedef enum logic {
      S_EXEC  = 1'b0,
      S_ABORT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state_q [N_REGIONS];
   logic [CNT_W-1:0]   cnt_q   [N_REGIONS];
   logic [N_REGIONS-1:0] cause_cpu_q, cause_dma_q;

   logic [N_REGIONS-1:0] hit_cpu, hit_dma, change, malformed;
   logic                 rearm;

   assign rearm = (pc == RESET_HANDLER);

   // A malformed range (min > max) is forced to produce no hits at all.
   always_comb begin
      hit_cpu   = '0;
      hit_dma   = '0;
      malformed = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         malformed[i] = exec_min[i*AW +: AW] > exec_max[i*AW +: AW];
         hit_cpu[i]   = data_en && !malformed[i] &&
                        (data_addr >= exec_min[i*AW +: AW]) &&
                        (data_addr <= exec_max[i*AW +: AW]);
         hit_dma[i]   = dma_en && !malformed[i] &&
                        (dma_addr >= exec_min[i*AW +: AW]) &&
                        (dma_addr <= exec_max[i*AW +: AW]);
      end
      change = hit_cpu | hit_dma;
   end

   // NOTE: all state is written with non-blocking assignments so every region samples
   // the same pre-edge values regardless of loop order.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REGIONS; i++) begin
            state_q[i] <= S_ABORT;
            cnt_q[i]   <= '0;
         end
         cause_cpu_q <= '0;
         cause_dma_q <= '0;
      end else begin
         for (int i = 0; i < N_REGIONS; i++) begin
            if (!region_en[i] || malformed[i]) begin
               state_q[i] <= S_ABORT;
            end else if (state_q[i] == S_EXEC && change[i]) begin
               state_q[i]     <= S_ABORT;
               cause_cpu_q[i] <= hit_cpu[i];
               cause_dma_q[i] <= hit_dma[i];
               if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else if (state_q[i] == S_ABORT && rearm && !change[i]) begin
               // A write coinciding with re-arm keeps the region aborted.
               state_q[i]     <= S_EXEC;
               cause_cpu_q[i] <= 1'b0;
               cause_dma_q[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      exec_fail = '0;
      abort_cnt = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         exec_fail[i]                 = (state_q[i] == S_ABORT);
         abort_cnt[i*CNT_W +: CNT_W]  = cnt_q[i];
      end
   end

   assign any_fail  = |(exec_fail & region_en);
   assign cause_cpu = cause_cpu_q;
   assign cause_dma = cause_dma_q;

endmodule

// File: tb/tb_vape_exec_flag_multi.sv
// Scoreboard bench for vape_exec_flag_multi (2 regions, AW=16, CNT_W=4): directed vectors
// push their expected next-cycle response, a monitor pops and compares after each edge.
module tb_vape_exec_flag_multi;

   localparam int N  = 2;
   localparam int AW = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] pc, data_addr, dma_addr;
   logic          data_en, dma_en;
   logic [N*AW-1:0] exec_min, exec_max;
   logic [N-1:0]  region_en;
   logic [N-1:0]  exec_fail, cause_cpu, cause_dma;
   logic          any_fail;
   logic [N*CW-1:0] abort_cnt;

   vape_exec_flag_multi #(
      .N_REGIONS(N), .AW(AW), .CNT_W(CW), .RESET_HANDLER(16'h0000)
   ) dut (
      .clk(clk), .rst(rst), .pc(pc),
      .data_addr(data_addr), .data_en(data_en),
      .dma_addr(dma_addr), .dma_en(dma_en),
      .exec_min(exec_min), .exec_max(exec_max), .region_en(region_en),
      .exec_fail(exec_fail), .any_fail(any_fail),
      .cause_cpu(cause_cpu), .cause_dma(cause_dma), .abort_cnt(abort_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [N-1:0]  fail;
      logic          any;
      logic [N-1:0]  cc;
      logic [N-1:0]  cd;
      logic [N*CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   localparam logic [N*AW-1:0] MIN_STD = {16'hF000, 16'hE000};
   localparam logic [N*AW-1:0] MAX_STD = {16'hF0FF, 16'hE0FF};
   localparam logic [AW-1:0]   PC_RUN  = 16'h1234;

   // Drive one cycle of inputs at the falling edge and queue the response expected after
   // the next rising edge. any_fail is judged against the enable applied in that cycle.
   task automatic vec(input string name, input logic r, input logic [AW-1:0] p,
                      input logic de, input logic [AW-1:0] da,
                      input logic me, input logic [AW-1:0] ma,
                      input logic [N*AW-1:0] mn, input logic [N*AW-1:0] mx,
                      input logic [N-1:0] en,
                      input logic [N-1:0] f, input logic [N-1:0] cc, input logic [N-1:0] cd,
                      input logic [CW-1:0] c0, input logic [CW-1:0] c1);
      exp_t e;
      @(negedge clk);
      rst = r; pc = p; data_en = de; data_addr = da; dma_en = me; dma_addr = ma;
      exec_min = mn; exec_max = mx; region_en = en;
      e.name = name; e.fail = f; e.any = |(f & en); e.cc = cc; e.cd = cd; e.cnt = {c1, c0};
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (exec_fail !== e.fail || any_fail !== e.any || cause_cpu !== e.cc ||
                cause_dma !== e.cd || abort_cnt !== e.cnt) begin
               n_err++;
               $display("FAIL %s: got fail=%b any=%b cpu=%b dma=%b cnt=%h, want fail=%b any=%b cpu=%b dma=%b cnt=%h",
                        e.name, exec_fail, any_fail, cause_cpu, cause_dma, abort_cnt,
                        e.fail, e.any, e.cc, e.cd, e.cnt);
            end
         end
      end
   end

   initial begin : stimulus
      logic [CW-1:0] c0;
      int            wait_cyc;
      rst = 1'b1; pc = '0; data_en = 1'b0; data_addr = '0; dma_en = 1'b0; dma_addr = '0;
      exec_min = MIN_STD; exec_max = MAX_STD; region_en = 2'b11;

      // Reset, then one re-arm cycle.
      vec("reset",        1, 16'h0000, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0);
      vec("first_rearm",  0, 16'h0000, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
      // Upper-bound CPU hit, then just-outside write.
      vec("cpu_hit_max",  0, PC_RUN, 1, 16'hE0FF, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b01, 2'b01, 2'b00, 1, 0);
      vec("cpu_outside",  0, PC_RUN, 1, 16'hE100, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b01, 2'b01, 2'b00, 1, 0);
      vec("rearm_r0",     0, 16'h0000, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0);
      // Simultaneous CPU and DMA hits on different regions.
      vec("cpu_dma_both", 0, PC_RUN, 1, 16'hE000, 1, 16'hF000, MIN_STD, MAX_STD, 2'b11, 2'b11, 2'b01, 2'b10, 2, 1);
      vec("rearm_w_dma",  0, 16'h0000, 0, 16'h0, 1, 16'hF010, MIN_STD, MAX_STD, 2'b11, 2'b10, 2'b00, 2'b10, 2, 1);
      vec("rearm_r1",     0, 16'h0000, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b00, 2'b00, 2'b00, 2, 1);
      // Malformed region1: held in ABORT, writes do not count.
      vec("malformed",    0, 16'h0000, 0, 16'h0, 0, 16'h0, {16'hF100, 16'hE000}, {16'hF000, 16'hE0FF}, 2'b11, 2'b10, 2'b00, 2'b00, 2, 1);
      vec("malf_write",   0, PC_RUN, 1, 16'hF080, 0, 16'h0, {16'hF100, 16'hE000}, {16'hF000, 16'hE0FF}, 2'b11, 2'b10, 2'b00, 2'b00, 2, 1);
      // Region1 disabled: any_fail follows region0 only.
      vec("r1_disabled",  0, PC_RUN, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b01, 2'b10, 2'b00, 2'b00, 2, 1);
      vec("r0_hit_r1off", 0, PC_RUN, 1, 16'hE010, 0, 16'h0, MIN_STD, MAX_STD, 2'b01, 2'b11, 2'b01, 2'b00, 3, 1);
      vec("rearm_r1off",  0, 16'h0000, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b01, 2'b10, 2'b00, 2'b00, 3, 1);
      vec("rearm_all",    0, 16'h0000, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b00, 2'b00, 2'b00, 3, 1);
      // Twenty abort/rearm pairs on region0: counter climbs from 3 and saturates at 15.
      c0 = 4'd3;
      for (int k = 0; k < 20; k++) begin
         if (c0 != 4'd15) c0 = c0 + 4'd1;
         vec("sat_abort", 0, PC_RUN, 1, 16'hE000, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b01, 2'b01, 2'b00, c0, 1);
         vec("sat_rearm", 0, 16'h0000, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b00, 2'b00, 2'b00, c0, 1);
      end
      vec("sat_final",    0, PC_RUN, 1, 16'hE080, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b01, 2'b01, 2'b00, 15, 1);
      vec("sat_rearm2",   0, 16'h0000, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b00, 2'b00, 2'b00, 15, 1);
      // Reset wins over a hit in the same cycle.
      vec("rst_with_hit", 1, PC_RUN, 1, 16'hE000, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0);
      vec("post_rst",     0, 16'h0000, 0, 16'h0, 0, 16'h0, MIN_STD, MAX_STD, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
      // Full-range region0 and one-address region1.
      vec("full_range",   0, PC_RUN, 0, 16'h0, 1, 16'hF001, {16'hF000, 16'h0000}, {16'hF000, 16'hFFFF}, 2'b11, 2'b01, 2'b00, 2'b01, 1, 0);
      vec("one_addr",     0, PC_RUN, 0, 16'h0, 1, 16'hF000, {16'hF000, 16'h0000}, {16'hF000, 16'hFFFF}, 2'b11, 2'b11, 2'b00, 2'b11, 1, 1);
      vec("rearm_blocked",0, 16'h0000, 0, 16'h0, 1, 16'hF000, {16'hF000, 16'h0000}, {16'hF000, 16'hFFFF}, 2'b11, 2'b11, 2'b00, 2'b11, 1, 1);
      vec("rearm_clean",  0, 16'h0000, 0, 16'h0, 0, 16'h0, {16'hF000, 16'h0000}, {16'hF000, 16'hFFFF}, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1);

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (exp_q.size() > 0) begin
         n_err++;
         $display("FAIL drain: %0d expected responses never compared, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

endmodule
